egress_arbiter: RTL and testbench

- Downstream stage of the transaction layer. Drains the four output FIFOs (P0..P3) into one 12-bit egress stream with a valid/ready handshake.
- Arbitration between ports is round-robin.
- Keeps a per-port count of delivered words, read back through the req/idx/counterOut/counterValid interface.
- Feeds the link-layer serializer.

---
 rtl/egress_arbiter_pkg.sv | 19 +
 rtl/egress_arbiter_rr_grant.sv | 27 ++
 rtl/egress_arbiter.sv | 135 +++++++++++++
 tb/tb_egress_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/egress_arbiter_pkg.sv
// Shared types and constants for the egress arbiter and its round-robin grant helper.
package egress_arbiter_pkg;

    localparam int unsigned DATA_W    = 12;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned NPORTS    = 4;
    localparam logic [2:0]  IDX_TOTAL = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StSend
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/egress_arbiter_rr_grant.sv
// Combinational round-robin grant: first set bit of nonempty at or after ptr (wrapping).
module rr_grant
    import egress_arbiter_pkg::*;
(
    input  logic [NPORTS-1:0] nonempty,
    input  logic [1:0]        ptr,
    output logic [1:0]        grant,
    output logic              any_valid
);

    logic [1:0] cand;

    always_comb begin
        grant     = ptr;
        any_valid = 1'b0;
        cand      = ptr;
        // Walk from the farthest offset down so the closest port to ptr wins last.
        for (int i = NPORTS - 1; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (nonempty[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/egress_arbiter.sv
// Drains four output FIFOs round-robin into one valid/ready egress stream and keeps
// saturating per-port and total delivered-word counters with a registered read port.
module egress_arbiter
    import egress_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              emptyP0,
    input  logic              emptyP1,
    input  logic              emptyP2,
    input  logic              emptyP3,
    input  logic [DATA_W-1:0] dataOutputP0,
    input  logic [DATA_W-1:0] dataOutputP1,
    input  logic [DATA_W-1:0] dataOutputP2,
    input  logic [DATA_W-1:0] dataOutputP3,
    output logic              popOutP0,
    output logic              popOutP1,
    output logic              popOutP2,
    output logic              popOutP3,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    input  logic              req,
    input  logic [2:0]        idx,
    output logic [CNT_W-1:0]  counterOut,
    output logic              counterValid
);

    state_e            state_q, state_d;
    logic [1:0]        grant_q, rr_q, rr_ptr, rr_sel;
    logic              rr_any, handshake, pop_en;
    logic [NPORTS-1:0] nonempty, pop;
    logic [CNT_W-1:0]  cnt_q [NPORTS];
    logic [CNT_W-1:0]  total_q, rd_val;
    logic [DATA_W-1:0] port_data;

    assign nonempty  = ~{emptyP3, emptyP2, emptyP1, emptyP0};
    // valid_out is only high in SEND, so this is the SEND-state handshake.
    assign handshake = valid_out & ready_in;
    // On a handshake the next pop is chosen from the already-advanced pointer.
    assign rr_ptr    = handshake ? grant_q + 2'd1 : rr_q;

    rr_grant u_rr_grant (
        .nonempty  (nonempty),
        .ptr       (rr_ptr),
        .grant     (rr_sel),
        .any_valid (rr_any)
    );

    always_comb begin
        state_d = state_q;
        pop_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rr_any) begin
                    pop_en  = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: state_d = StSend;
            StSend: begin
                if (handshake) begin
                    pop_en  = rr_any;
                    state_d = rr_any ? StWait : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop = '0;
        if (pop_en) pop[rr_sel] = 1'b1;
    end

    assign {popOutP3, popOutP2, popOutP1, popOutP0} = pop;

    always_comb begin
        unique case (grant_q)
            2'd0:    port_data = dataOutputP0;
            2'd1:    port_data = dataOutputP1;
            2'd2:    port_data = dataOutputP2;
            default: port_data = dataOutputP3;
        endcase
    end

    always_comb begin
        rd_val = '0;
        if (idx < IDX_TOTAL)       rd_val = cnt_q[idx[1:0]];
        else if (idx == IDX_TOTAL) rd_val = total_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 2'd0;
            rr_q         <= 2'd0;
            data_out     <= '0;
            valid_out    <= 1'b0;
            counterOut   <= '0;
            counterValid <= 1'b0;
            total_q      <= '0;
            for (int i = 0; i < NPORTS; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (pop_en) grant_q <= rr_sel;

            if (state_q == StWait) begin
                data_out  <= port_data;
                valid_out <= 1'b1;
            end else if (handshake) begin
                valid_out <= 1'b0;
            end

            if (init)           rr_q <= 2'd0;
            else if (handshake) rr_q <= grant_q + 2'd1;

            // init clears first; a coinciding handshake then counts as the first word.
            for (int i = 0; i < NPORTS; i++) begin
                if (init) begin
                    cnt_q[i] <= (handshake && grant_q == 2'(i)) ? CNT_W'(1) : '0;
                end else if (handshake && grant_q == 2'(i)) begin
                    cnt_q[i] <= sat_inc(cnt_q[i]);
                end
            end
            if (init)           total_q <= handshake ? CNT_W'(1) : '0;
            else if (handshake) total_q <= sat_inc(total_q);

            counterValid <= req;
            if (req) counterOut <= rd_val;
        end
    end

endmodule

// File: tb/tb_egress_arbiter.sv
// Randomized self-checking bench: FIFO model plus a queue-based round-robin reference.
module tb_egress_arbiter;

    logic        clk = 1'b0;
    logic        reset, init, ready_in, req;
    logic [2:0]  idx;
    logic [3:0]  empty;
    logic [11:0] fdata [4];
    logic        popOutP0, popOutP1, popOutP2, popOutP3;
    logic [3:0]  pops;
    logic [11:0] data_out;
    logic        valid_out;
    logic [4:0]  counterOut;
    logic        counterValid;

    logic [11:0] q  [4][$];
    logic [11:0] mq [4][$];
    int          m_cnt [5];
    int          m_ptr;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;
    assign pops = {popOutP3, popOutP2, popOutP1, popOutP0};

    egress_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .emptyP0      (empty[0]),
        .emptyP1      (empty[1]),
        .emptyP2      (empty[2]),
        .emptyP3      (empty[3]),
        .dataOutputP0 (fdata[0]),
        .dataOutputP1 (fdata[1]),
        .dataOutputP2 (fdata[2]),
        .dataOutputP3 (fdata[3]),
        .popOutP0     (popOutP0),
        .popOutP1     (popOutP1),
        .popOutP2     (popOutP2),
        .popOutP3     (popOutP3),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .req          (req),
        .idx          (idx),
        .counterOut   (counterOut),
        .counterValid (counterValid)
    );

    function automatic void refresh_empty();
        for (int i = 0; i < 4; i++) empty[i] = (q[i].size() == 0);
    endfunction

    function automatic int words_left();
        int n = 0;
        for (int i = 0; i < 4; i++) n += mq[i].size();
        return n;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_ptr = 0;
    endfunction

    // Reference: next word is the head of the first non-empty port at or after the pointer.
    function automatic bit model_accept(output logic [11:0] exp);
        int g;
        for (int k = 0; k < 4; k++) begin
            g = (m_ptr + k) % 4;
            if (mq[g].size() > 0) begin
                exp = mq[g].pop_front();
                if (m_cnt[g] < 31) m_cnt[g]++;
                if (m_cnt[4] < 31) m_cnt[4]++;
                m_ptr = (g + 1) % 4;
                return 1'b1;
            end
        end
        exp = '0;
        return 1'b0;
    endfunction

    task automatic push(input int p, input logic [11:0] d);
        q[p].push_back(d);
        mq[p].push_back(d);
        refresh_empty();
    endtask

    // Advance one clock; a pop seen this cycle presents the FIFO head the next cycle.
    task automatic step();
        logic [3:0] p;
        p = pops;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (p[i] && q[i].size() > 0) fdata[i] = q[i].pop_front();
        refresh_empty();
    endtask

    task automatic pulse_init();
        init = 1'b1;
        #1;
        step();
        init = 1'b0;
        model_clear();
    endtask

    task automatic test_counter_readback(input string tag);
        int sel, exp;
        for (int i = 0; i < 7; i++) begin
            sel = (i == 0) ? 7 : (i == 1) ? 5 : i - 2;
            req = 1'b1;
            idx = 3'(sel);
            #1;
            step();
            req = 1'b0;
            #1;
            exp = (sel < 5) ? m_cnt[sel] : 0;
            n_tests++;
            if (counterValid !== 1'b1 || counterOut !== 5'(exp)) begin
                n_fail++;
                $display("FAIL %s read idx%0d: valid=%b out=%0d expected valid=1 out=%0d",
                         tag, sel, counterValid, counterOut, exp);
            end
        end
        step();
        #1;
        n_tests++;
        if (counterValid !== 1'b0 || counterOut !== 5'(m_cnt[4])) begin
            n_fail++;
            $display("FAIL %s read_hold: valid=%b out=%0d expected valid=0 out=%0d",
                     tag, counterValid, counterOut, m_cnt[4]);
        end
    endtask

    task automatic test_drain(input string tag, input int ready_pct, input int budget);
        logic [11:0] exp, held;
        bit          ok, hold_chk, pd1, pd2;
        int          cyc;
        hold_chk = 1'b0;
        pd1      = 1'b0;
        pd2      = 1'b0;
        held     = '0;
        cyc      = 0;
        forever begin
            ready_in = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (words_left() == 0 && !valid_out && pops == 4'd0 && !pd1) break;
            if (cyc == budget) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s drain_timeout: words_left=%0d expected 0", tag, words_left());
                break;
            end
            n_tests++;
            if ((pops & empty) != 4'd0 || $countones(pops) > 1 ||
                (valid_out && !ready_in && pops != 4'd0)) begin
                n_fail++;
                $display("FAIL %s pop_legal: pops=%b empty=%b valid=%b ready=%b",
                         tag, pops, empty, valid_out, ready_in);
            end
            if (pd1) begin
                n_tests++;
                if (valid_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s wait_valid: valid_out=%b expected 0", tag, valid_out);
                end
            end
            if (pd2) begin
                n_tests++;
                if (valid_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s send_valid: valid_out=%b expected 1", tag, valid_out);
                end
            end
            if (hold_chk) begin
                n_tests++;
                if (valid_out !== 1'b1 || data_out !== held) begin
                    n_fail++;
                    $display("FAIL %s hold: valid=%b data=%h expected valid=1 data=%h",
                             tag, valid_out, data_out, held);
                end
            end
            if (valid_out && ready_in) begin
                ok = model_accept(exp);
                n_tests++;
                if (!ok || data_out !== exp) begin
                    n_fail++;
                    $display("FAIL %s word: data_out=%h expected %h (model_has=%b)",
                             tag, data_out, exp, ok);
                end
            end
            hold_chk = valid_out && !ready_in;
            held     = data_out;
            pd2      = pd1;
            pd1      = (pops != 4'd0);
            step();
            cyc++;
        end
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        init     = 1'b0;
        ready_in = 1'b0;
        req      = 1'b0;
        idx      = 3'd0;
        for (int i = 0; i < 4; i++) fdata[i] = '0;
        refresh_empty();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        model_clear();
        n_tests++;
        if (pops !== 4'd0 || valid_out !== 1'b0 || data_out !== 12'd0) begin
            n_fail++;
            $display("FAIL reset outputs: pops=%b valid=%b data=%h expected 0/0/000",
                     pops, valid_out, data_out);
        end
        n_tests++;
        if (counterOut !== 5'd0 || counterValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset counter_port: out=%0d valid=%b expected 0/0",
                     counterOut, counterValid);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            n_tests++;
            if (pops !== 4'd0 || valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL idle cycle%0d: pops=%b valid=%b expected 0/0", i, pops, valid_out);
            end
        end
        test_counter_readback("reset");
    endtask

    task automatic test_single_port();
        push(0, 12'h001);
        push(0, 12'h002);
        push(0, 12'h003);
        test_drain("single", 100, 40);
        test_counter_readback("single");
    endtask

    task automatic test_round_robin();
        pulse_init();
        for (int w = 0; w < 2; w++)
            for (int p = 0; p < 4; p++) push(p, {2'(p), 10'(w + 16)});
        test_drain("rr", 100, 60);
        test_counter_readback("rr");
    endtask

    task automatic test_backpressure();
        logic [11:0] held, exp;
        bit          ok;
        int          cyc;
        ready_in = 1'b0;
        push(1, 12'h4A1);
        push(1, 12'h4A2);
        cyc = 0;
        #1;
        while (!valid_out && cyc < 20) begin
            step();
            #1;
            cyc++;
        end
        n_tests++;
        if (valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_valid: valid_out=%b expected 1 within 20 cycles", valid_out);
        end
        held = data_out;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            n_tests++;
            if (valid_out !== 1'b1 || data_out !== held || pops !== 4'd0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b data=%h pops=%b expected 1/%h/0000",
                         i, valid_out, data_out, pops, held);
            end
        end
        ready_in = 1'b1;
        #1;
        ok = model_accept(exp);
        n_tests++;
        if (!ok || data_out !== exp || pops !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_handshake: data=%h pops=%b expected %h/0010", data_out, pops, exp);
        end
        step();
        ready_in = 1'b0;
        #1;
        n_tests++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drop: valid_out=%b expected 0", valid_out);
        end
        step();
        test_counter_readback("bp");
        test_drain("bp_tail", 100, 20);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 4; p++) begin
                int n;
                n = $urandom_range(0, 5);
                for (int k = 0; k < n; k++) push(p, {2'(p), 10'($urandom)});
            end
            test_drain("random", 55, 400);
        end
        test_counter_readback("random");
    endtask

    task automatic test_saturation_init();
        pulse_init();
        for (int k = 0; k < 35; k++) push(2, {2'd2, 10'(k)});
        test_drain("sat", 70, 600);
        test_counter_readback("sat");
        pulse_init();
        test_counter_readback("init_clear");
    endtask

    task automatic test_init_collision();
        logic [11:0] exp;
        bit          ok;
        int          cyc;
        ready_in = 1'b0;
        push(3, 12'hC3C);
        cyc = 0;
        #1;
        while (!valid_out && cyc < 20) begin
            step();
            #1;
            cyc++;
        end
        init     = 1'b1;
        ready_in = 1'b1;
        #1;
        ok = model_accept(exp);
        n_tests++;
        if (!ok || valid_out !== 1'b1 || data_out !== exp) begin
            n_fail++;
            $display("FAIL init_hs word: valid=%b data=%h expected 1/%h", valid_out, data_out, exp);
        end
        step();
        init     = 1'b0;
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_cnt[3] = 1;
        m_cnt[4] = 1;
        m_ptr    = 0;
        test_counter_readback("init_hs");
    endtask

    task automatic test_reset_mid_wait();
        int          cyc;
        logic [11:0] lost;
        ready_in = 1'b0;
        push(1, 12'h511);
        push(1, 12'h512);
        cyc = 0;
        #1;
        while (!pops[1] && cyc < 20) begin
            step();
            #1;
            cyc++;
        end
        step();
        reset = 1'b1;
        push(0, 12'h0C5);
        #1;
        step();
        reset = 1'b0;
        lost  = mq[1].pop_front();
        model_clear();
        req = 1'b1;
        idx = 3'd4;
        #1;
        n_tests++;
        if (valid_out !== 1'b0 || pops !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_wait: valid=%b pops=%b expected 0/0001 (dropped %h)",
                     valid_out, pops, lost);
        end
        step();
        req = 1'b0;
        #1;
        n_tests++;
        if (counterOut !== 5'd0 || counterValid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait total: out=%0d valid=%b expected 0/1", counterOut, counterValid);
        end
        test_drain("rst_wait", 100, 20);
        test_counter_readback("rst_wait");
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_random();
        test_saturation_init();
        test_init_collision();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
